// File: rtl/mtm_alu_deserializer_if.sv
// Serial-in / operand-out bundle of the MTM ALU deserializer.
// master = serial source and result consumer; slave = the deserializer itself.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  op_o;
  logic        valid_o;
  logic        err_data_o;
  logic        err_crc_o;
  logic        err_op_o;

  modport master (
    output sin,
    input  a_o, b_o, op_o, valid_o, err_data_o, err_crc_o, err_op_o
  );

  modport slave (
    input  sin,
    output a_o, b_o, op_o, valid_o, err_data_o, err_crc_o, err_op_o
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// Deserializes 11-bit DATA/CTL packets into a checked ALU command (A, B, op).
// Optional frame timeout: define MTM_ALU_DESER_TIMEOUT_EN to enable it.
module mtm_alu_deserializer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mtm_alu_deserializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  state_t      state_q;
  logic        is_ctl_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [3:0]  data_cnt_q;
  logic [3:0]  data_cnt_d;
  logic [63:0] buf_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        valid_q;
  logic        err_data_q;
  logic        err_crc_q;
  logic        err_op_q;
  logic [3:0]  crc_d;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MTM_ALU_DESER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q;
`endif

  // CRC4 (x^4 + x + 1, init 0) over the 68 bits, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = msg[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  always_comb begin
    crc_d      = crc4({buf_q, 1'b1, shift_q[6:4]});
    data_cnt_d = (data_cnt_q == 4'hF) ? 4'hF : data_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_ctl_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_cnt_q <= 4'd0;
      buf_q      <= 64'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      valid_q    <= 1'b0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
`ifdef MTM_ALU_DESER_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      valid_q    <= 1'b0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!bus.sin) state_q <= TYPE;
        end
        TYPE: begin
          is_ctl_q  <= bus.sin;
          bit_cnt_q <= 3'd0;
          state_q   <= PAYLOAD;
        end
        PAYLOAD: begin
          shift_q   <= {shift_q[6:0], bus.sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end
        STOP: begin
          // Return to IDLE unconditionally so a start bit on the very next clock is caught.
          state_q <= IDLE;
          if (!bus.sin) begin
            err_data_q <= 1'b1;
            data_cnt_q <= 4'd0;
            buf_q      <= 64'd0;
          end else if (!is_ctl_q) begin
            buf_q      <= {buf_q[55:0], shift_q};
            data_cnt_q <= data_cnt_d;
          end else begin
            data_cnt_q <= 4'd0;
            buf_q      <= 64'd0;
            if (data_cnt_q != 4'd8) begin
              err_data_q <= 1'b1;
            end else if (shift_q[3:0] != crc_d) begin
              err_crc_q <= 1'b1;
            end else if (shift_q[5]) begin
              // Legal ops are 000/001/100/101, i.e. exactly those with bit 1 clear.
              err_op_q <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              a_q     <= buf_q[63:32];
              b_q     <= buf_q[31:0];
              op_q    <= shift_q[6:4];
            end
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef MTM_ALU_DESER_TIMEOUT_EN
      if (state_q == IDLE && bus.sin && data_cnt_q != 4'd0) begin
        if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt_q <= '0;
          err_data_q <= 1'b1;
          data_cnt_q <= 4'd0;
          buf_q      <= 64'd0;
        end else begin
          idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
      end else begin
        idle_cnt_q <= '0;
      end
`endif
    end
  end

  assign bus.a_o        = a_q;
  assign bus.b_o        = b_q;
  assign bus.op_o       = op_q;
  assign bus.valid_o    = valid_q;
  assign bus.err_data_o = err_data_q;
  assign bus.err_crc_o  = err_crc_q;
  assign bus.err_op_o   = err_op_q;

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32, giving the mid-packet idle limit in clocks; it is used only when MTM_ALU_DESER_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all sampling is on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sin, input, 1 bit: serial input; idles high.
REQ-005 The block SHALL have port a_o, output, 32 bits: operand A, taken from the first four data bytes.
REQ-006 The block SHALL have port b_o, output, 32 bits: operand B, taken from the second four data bytes.
REQ-007 The block SHALL have port op_o, output, 3 bits: operation code from CTL[6:4].
REQ-008 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse marking a good frame.
REQ-009 The block SHALL have ports err_data_o, err_crc_o and err_op_o, each output, 1 bit: one-cycle error pulses.

Function
REQ-010 Packet format SHALL be 11 bits, one bit per clock, in this order:
- start bit = 0;
- type bit (0 = DATA, 1 = CTL);
- 8 payload bits, MSB first;
- stop bit = 1.
REQ-011 The packet FSM SHALL have states IDLE, TYPE, PAYLOAD, STOP.
- IDLE -> TYPE when sin = 0 is sampled.
- TYPE -> PAYLOAD after one bit.
- PAYLOAD -> STOP after 8 bits, counted by a 3-bit counter.
- STOP -> IDLE after one bit.
REQ-012 Any number of idle-high bits (including zero) SHALL be accepted between packets.
REQ-013 A DATA packet with a good stop bit SHALL shift its byte into a 64-bit buffer and increment a 4-bit data count that saturates at 15.
- The first received byte lands in A[31:24].
- The eighth received byte lands in B[7:0].
REQ-014 A CTL packet with a good stop bit SHALL end the frame.
- Response: exactly one output pulse, 1 clock after the CTL stop bit is sampled.
- After the response: data count cleared and FSM in IDLE.
REQ-015 Frame evaluation SHALL use this priority, and exactly one of the four outputs SHALL pulse per frame:
- data count != 8 -> err_data_o;
- else CTL[3:0] != CRC4 -> err_crc_o;
- else CTL[6:4] not in {000, 001, 100, 101} -> err_op_o;
- else valid_o.
REQ-016 CRC4 SHALL be computed as follows:
- polynomial x^4 + x + 1, initial value 0000;
- computed over the 68 bits {A, B, 1'b1, CTL[6:4]};
- first bit in is A[31];
- computed serially as the bits arrive, or in parallel at CTL.
REQ-017 On valid_o, a_o, b_o and op_o SHALL update in the same cycle and hold until the next valid_o; error frames SHALL leave them unchanged.
REQ-018 A stop bit of 0 (framing error) SHALL pulse err_data_o 1 clock later, discard the partial frame, clear the data count, and go to IDLE.
REQ-019 A start bit arriving in the cycle immediately after a stop bit SHALL be accepted with no lost bit.

Reset
REQ-020 While rst_n = 0 the block SHALL asynchronously force:
- FSM = IDLE;
- counters and buffer = 0;
- a_o = 0, b_o = 0, op_o = 0;
- all pulse outputs = 0.
REQ-021 Reset asserted mid-packet or mid-frame SHALL discard all partial data; the first packet after rst_n rises SHALL be treated as the first byte of a new frame.

Configuration
REQ-022 With MTM_ALU_DESER_TIMEOUT_EN defined, the block SHALL apply a frame timeout:
- sin staying high for TIMEOUT_CYCLES consecutive clocks while the data count > 0 and no CTL has arrived -> discard the frame, pulse err_data_o once, clear the data count.
REQ-023 Without MTM_ALU_DESER_TIMEOUT_EN, the block SHALL implement no timeout logic, and a partial frame SHALL wait indefinitely for a CTL packet.

Verification
REQ-024 Scenario, good frame:
- stimulus: A = 0x00000003, B = 0x00000007, op 100, correct CRC;
- response: valid_o pulse 1 clock after the CTL stop bit, with a_o = 3, b_o = 7, op_o = 100.
REQ-025 Scenario, bad CRC:
- stimulus: same operands, CTL = 0x40 (CRC field 0000, wrong);
- response: err_crc_o pulse, valid_o stays 0, a_o/b_o/op_o unchanged.
REQ-026 Scenario, short frame:
- stimulus: DATA 0x55, DATA 0x0F, CTL 0x50;
- response: err_data_o pulse, no other pulse.
REQ-027 Scenario, bad opcode:
- stimulus: 8 DATA bytes 0xFF, op 111, correct CRC;
- response: err_op_o pulse.
REQ-028 Scenario, back-to-back packets and random frames:
- stimulus: 1000 random valid frames cycling through ops 000/001/100/101, no idle bits between packets;
- response: 1000 valid_o pulses, each with matching a_o/b_o/op_o.
REQ-029 Scenario, reset and timeout:
- stimulus: rst_n pulsed low after 5 DATA bytes, then a full valid frame;
- response: a single valid_o with the new operands.
- With MTM_ALU_DESER_TIMEOUT_EN defined, additionally: 3 DATA bytes then 32 idle clocks -> err_data_o pulse.
